// File: rtl/mux4_arbiter.sv
// Round-robin arbiter/sequencer for a shared four-input port: owns the Mux4 select,
// holds a grant for a whole transaction and force-releases it after max_beats beats.
module mux4_arbiter #(
  parameter int max_beats = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_val,
  input  logic [3:0] req_last,
  output logic [3:0] req_rdy,
  output logic       out_val,
  input  logic       out_rdy,
  output logic       out_last,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       busy
);

  localparam int            CW       = $clog2(max_beats + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(max_beats - 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_ptr;
  logic [1:0]    r_sel;
  logic [3:0]    r_gnt;
  logic [CW-1:0] r_cnt;

  logic [7:0]    w_dbl;
  logic [3:0]    w_rot;
  logic [1:0]    w_off;
  logic [1:0]    w_win;
  logic          w_any;
  logic          w_hs;
  logic          w_release;

  // Rotate the request vector so bit 0 is the current priority holder.
  assign w_dbl = {req_val, req_val};
  assign w_rot = w_dbl[r_ptr +: 4];
  assign w_any = |req_val;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_rot[i]) w_off = 2'(i);
    end
    w_win = r_ptr + w_off;
  end

  assign busy      = (r_state == S_BUSY);
  assign sel       = r_sel;
  assign gnt       = r_gnt;
  assign out_val   = busy & req_val[r_sel];
  assign req_rdy   = busy ? ({3'b000, out_rdy} << r_sel) : 4'b0000;
  assign out_last  = out_val & (req_last[r_sel] | (r_cnt == LAST_CNT));
  assign w_hs      = out_val & out_rdy;
  assign w_release = w_hs & out_last;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any)     w_state_nxt = S_BUSY;
      S_BUSY:  if (w_release) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= 2'd0;
      r_sel <= 2'd0;
      r_gnt <= 4'b0000;
      r_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_any) begin
        r_sel <= w_win;
        r_gnt <= 4'b0001 << w_win;
        r_cnt <= '0;
      end
    end else if (w_hs) begin
      if (out_last) begin
        // sel deliberately keeps its value while idle.
        r_gnt <= 4'b0000;
        r_ptr <= r_sel + 2'd1;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Scoreboard bench for mux4_arbiter (max_beats=4): expected handshakes are queued
// as stimulus is driven and popped by a monitor on every observed handshake.
module tb_mux4_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_val;
  logic [3:0] req_last;
  logic [3:0] req_rdy;
  logic       out_val;
  logic       out_rdy;
  logic       out_last;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       busy;

  typedef struct packed {
    logic [1:0] id;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp;
  int    n_bad;

  bit rdy_t [6] = '{1, 0, 1, 0, 1, 1};
  bit val_t [6] = '{1, 1, 1, 1, 0, 1};
  bit last_t[6] = '{0, 0, 0, 0, 0, 1};

  mux4_arbiter #(.max_beats(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_val  (req_val),
    .req_last (req_last),
    .req_rdy  (req_rdy),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_last (out_last),
    .sel      (sel),
    .gnt      (gnt),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input bit last);
    beat_t b;
    b.id   = 2'(id);
    b.last = last;
    exp_q.push_back(b);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst      = 1'b0;
    req_val  = 4'b0000;
    req_last = 4'b0000;
    out_rdy  = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  // Handshake monitor: every accepted beat must match the next queued expectation.
  always @(negedge clk) begin
    if (rst && out_val && out_rdy) begin
      if (exp_q.size() == 0) begin
        check("hs_unexpected", 32'(exp_q.size()), 1);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        check("hs_sel", 32'(sel), 32'(b.id));
        check("hs_last", 32'(out_last), 32'(b.last));
        check("hs_rdy", 32'(req_rdy), 32'(4'b0001 << b.id));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b0;
    req_val  = 4'b0000;
    req_last = 4'b0000;
    out_rdy  = 1'b0;

    // Reset values hold under random inputs.
    for (int i = 0; i < 4; i++) begin
      step();
      req_val  = 4'($urandom_range(15, 1));
      req_last = 4'($urandom);
      out_rdy  = 1'($urandom);
      @(negedge clk);
      check("rst_gnt", 32'(gnt), 0);
      check("rst_sel", 32'(sel), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_out_val", 32'(out_val), 0);
      check("rst_req_rdy", 32'(req_rdy), 0);
    end
    step();
    rst      = 1'b1;
    req_val  = 4'b0000;
    req_last = 4'b0000;
    out_rdy  = 1'b0;
    step();

    // Single request on requester 2.
    req_val  = 4'b0100;
    req_last = 4'b0100;
    out_rdy  = 1'b1;
    push(2, 1'b1);
    step();
    @(negedge clk);
    check("single_sel", 32'(sel), 2);
    check("single_gnt", 32'(gnt), 4);
    check("single_rdy", 32'(req_rdy), 4);
    check("single_last", 32'(out_last), 1);
    check("single_busy", 32'(busy), 1);
    step();
    req_val = 4'b0000;
    @(negedge clk);
    check("single_idle_gnt", 32'(gnt), 0);
    check("single_idle_busy", 32'(busy), 0);
    check("single_sel_hold", 32'(sel), 2);

    // Round-robin fairness from ptr=0: grants 0,1,2,3,0 every other cycle.
    do_reset();
    req_val  = 4'b1111;
    req_last = 4'b1111;
    out_rdy  = 1'b1;
    push(0, 1'b1);
    push(1, 1'b1);
    push(2, 1'b1);
    push(3, 1'b1);
    push(0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 9) req_val = 4'b0000;
      @(negedge clk);
      check($sformatf("rr_gnt_%0d", k), 32'(gnt),
            (k % 2 == 0) ? (1 << ((k / 2) % 4)) : 0);
    end

    // Burst with backpressure and a bubble on requester 1; requester 0 waits.
    step();
    req_val  = 4'b0011;
    req_last = 4'b0001;
    out_rdy  = 1'b1;
    push(1, 1'b0);
    push(1, 1'b0);
    push(1, 1'b1);
    push(0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      out_rdy     = rdy_t[i];
      req_val[1]  = val_t[i];
      req_last[1] = last_t[i];
      @(negedge clk);
      check($sformatf("burst_sel_%0d", i), 32'(sel), 1);
      check($sformatf("burst_gnt_%0d", i), 32'(gnt), 2);
      if (i == 4) begin
        check("bubble_out_val", 32'(out_val), 0);
        check("bubble_req_rdy", 32'(req_rdy), 2);
      end
    end
    step();
    @(negedge clk);
    check("burst_release_gnt", 32'(gnt), 0);
    check("burst_release_busy", 32'(busy), 0);
    step();
    @(negedge clk);
    check("waiter_gnt", 32'(gnt), 1);
    check("waiter_sel", 32'(sel), 0);
    step();
    req_val = 4'b0000;
    @(negedge clk);
    check("waiter_done_busy", 32'(busy), 0);

    // Forced release after 4 beats of requester 3; ptr then favours requester 0.
    req_val  = 4'b1000;
    req_last = 4'b0000;
    out_rdy  = 1'b1;
    push(3, 1'b0);
    push(3, 1'b0);
    push(3, 1'b0);
    push(3, 1'b1);
    push(0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      check($sformatf("force_sel_%0d", i), 32'(sel), 3);
      check($sformatf("force_last_%0d", i), 32'(out_last), (i == 3) ? 1 : 0);
    end
    step();
    req_val  = 4'b1001;
    req_last = 4'b0001;
    @(negedge clk);
    check("force_release_busy", 32'(busy), 0);
    step();
    @(negedge clk);
    check("force_next_gnt", 32'(gnt), 1);
    step();
    req_val = 4'b0000;
    @(negedge clk);
    check("force_done_busy", 32'(busy), 0);

    // Reset during beat 2 of a requester-2 burst.
    req_val  = 4'b0100;
    req_last = 4'b0000;
    out_rdy  = 1'b1;
    push(2, 1'b0);
    step();
    @(negedge clk);
    check("mid_beat1_sel", 32'(sel), 2);
    step();
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_out_val", 32'(out_val), 0);
    check("mid_rst_req_rdy", 32'(req_rdy), 0);
    check("mid_rst_sel", 32'(sel), 0);
    req_val  = 4'b0101;
    req_last = 4'b0101;
    step();
    rst = 1'b1;
    push(0, 1'b1);
    step();
    @(negedge clk);
    check("post_rst_gnt", 32'(gnt), 1);
    check("post_rst_sel", 32'(sel), 0);
    step();
    req_val = 4'b0000;
    @(negedge clk);
    check("post_rst_done_busy", 32'(busy), 0);

    step();
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux4_arbiter.md
# mux4_arbiter

Round-robin arbiter and sequencer for a four-input shared datapath port. It owns the 2-bit select of the downstream `Mux4` and decides which of four requesters drives it. It also routes the downstream handshake back to the winning requester. A grant is held for a whole transaction (multi-beat, terminated by `last`) and is forcibly released after `max_beats` accepted beats, which guarantees fairness.

## Interface

- `max_beats`, default 16: maximum accepted beats per grant before forced release; legal range 1..255.
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req_val` input 4: per-requester valid; bit i belongs to requester i.
- `req_last` input 4: per-requester last-beat flag; sampled only with a handshake.
- `req_rdy` output 4: per-requester ready; at most one bit set.
- `out_val` output 1: valid toward the shared downstream port.
- `out_rdy` input 1: downstream ready.
- `out_last` output 1: last beat of the current grant (requester last or forced release).
- `sel` output 2: select for the downstream `Mux4`; equals the index of the granted requester.
- `gnt` output 4: one-hot grant; all-zero when idle.
- `busy` output 1: high while in BUSY.

## Operation

- Two states: IDLE and BUSY. There is also a 2-bit priority pointer `ptr` and a beat counter `cnt` of width clog2(max_beats+1).
- Reset (`rst`=0, asynchronous) forces:
  - state=IDLE, `ptr`=0, `cnt`=0, `sel`=0, `gnt`=0;
  - `busy`=0, `out_val`=0, `out_last`=0, `req_rdy`=0.
  - Deassertion takes effect at the first rising edge after `rst` rises.
- IDLE behaviour:
  - All `req_rdy`=0 and `out_val`=0.
  - If any `req_val` bit is set, the winner is the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - At the next edge: state=BUSY, `sel`=winner, `gnt`=one-hot(winner), `cnt`=0.
- BUSY behaviour, with g=`sel`:
  - `out_val` = `req_val[g]`; `req_rdy[g]` = `out_rdy`; all other `req_rdy` bits are 0.
  - `out_last` = `out_val` & (`req_last[g]` | (`cnt` == max_beats-1)).
  - A handshake occurs when `out_val` & `out_rdy`. Each handshake increments `cnt`.
  - A handshake with `out_last`=1 releases the grant. At the next edge: state=IDLE, `gnt`=0, `ptr`=(g+1) mod 4, `cnt`=0.
  - `sel` holds its last value while idle; it is not reset to 0 on release.
- Bubbles: the granted requester may drop `req_val` mid-transaction. The grant is held indefinitely, and other requesters are ignored until release.
- Requests from non-granted requesters never affect BUSY state; they wait.
- max_beats=1: every accepted beat is `out_last`, so every beat releases the grant.
- `sel` and `gnt` change only on state transitions and never mid-transaction. The downstream mux input is therefore stable from the first beat through the last beat.

## Timing

- Arbitration latency is 1 cycle. If `req_val` rises at edge t while IDLE, `gnt`/`sel` are valid after edge t+1, and the first handshake can occur in cycle t+1.
- Release-to-regrant: a last handshake in cycle t gives IDLE in cycle t+1 and the next BUSY in cycle t+2. The minimum is 2 cycles per single-beat transaction, so sustained single-beat throughput is 1 beat per 2 cycles.
- Outputs are combinational from registered state plus `req_val`/`req_last`/`out_rdy`: `out_val`, `out_last`, `req_rdy`.
- Outputs driven directly by registers: `sel`, `gnt`, `busy`.
- There is no combinational path from `out_rdy` to `out_val`.
- Reset asserted mid-transaction: outputs reach reset values immediately (asynchronously). The in-flight transaction is abandoned, and the next grant restarts priority at requester 0.

## Test plan

- Reset values: hold `rst`=0 with random inputs → `gnt`=0, `sel`=0, `busy`=0, `out_val`=0, `req_rdy`=0.
- Single request: `req_val`=4'b0100 with `req_last`=1 and `out_rdy`=1.
  - Cycle 1: `sel`=2, `gnt`=4'b0100, `req_rdy`=4'b0100, `out_last`=1.
  - Cycle 2: IDLE, `gnt`=0.
- Round-robin fairness: `req_val`=4'b1111 held, every beat last, `out_rdy`=1 → grant order 0,1,2,3,0, one grant every 2 cycles.
- Burst with backpressure: requester 1, 3 beats with last on beat 3, `out_rdy` toggling 1,0,1,0,1.
  - Exactly 3 handshakes occur, and `sel`=1 throughout.
  - Requester 0 waiting is granted only after the release.
  - A bubble on `req_val[1]` mid-burst keeps the grant.
- Forced release: max_beats=4, requester 3 never asserts last → `out_last`=1 on beat 4, grant released, and `ptr` then favours requester 0.
- Reset mid-burst: assert `rst`=0 during beat 2 of a requester-2 burst → `gnt`=0 immediately. After release of reset, with `req_val`=4'b0101, requester 0 wins.
